// File: rtl/alu_arb_pkg.sv
// Shared types for the arbitrated ALU: operand width, ALU opcode, request payload
// and the result-slot state.
package alu_arb_pkg;

   localparam int unsigned Xlen = 32;

   typedef enum logic [1:0] {
      AluAdd    = 2'd0,
      AluSleft  = 2'd1,
      AluBranch = 2'd2,
      AluFunct  = 2'd3
   } aluop_e;

   typedef struct packed {
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic            itype;
      aluop_e          aluop;
      logic [Xlen-1:0] a;
      logic [Xlen-1:0] b;
   } alu_req_t;

   typedef enum logic {
      StEmpty = 1'b0,
      StFull  = 1'b1
   } state_e;

endpackage

// File: rtl/alu_arb_if.sv
// Request/response bus between NumReq requesters and the shared ALU.
//   req_valid_i / req_ready_o : per-requester operation handshake
//   req_i                     : per-requester operation payload
//   rsp_valid_o / rsp_ready_i : per-requester result handshake
//   rsp_res_o / rsp_zero_o    : shared registered result and branch flag
interface alu_arb_if #(
   parameter int unsigned NumReq = 2
);
   import alu_arb_pkg::*;

   logic [NumReq-1:0] req_valid_i;
   logic [NumReq-1:0] req_ready_o;
   alu_req_t          req_i [NumReq];
   logic [NumReq-1:0] rsp_valid_o;
   logic [NumReq-1:0] rsp_ready_i;
   logic [Xlen-1:0]   rsp_res_o;
   logic              rsp_zero_o;

   modport slave (
      input  req_valid_i, req_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_res_o, rsp_zero_o
   );

   modport master (
      output req_valid_i, req_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_res_o, rsp_zero_o
   );

endinterface

// File: rtl/alu32.sv
// 32-bit combinational ALU.
//   funct3/funct7/itype/aluop : operation select
//   a, b                      : operands (b already holds the immediate for I-type)
//   res_c                     : arithmetic/logic result
//   cond_c                    : branch condition taken
//   legal_c                   : encoding is defined for the selected aluop
module alu32
   import alu_arb_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic            itype,
   input  aluop_e          aluop,
   input  logic [Xlen-1:0] a,
   input  logic [Xlen-1:0] b,
   output logic [Xlen-1:0] res_c,
   output logic            cond_c,
   output logic            legal_c
);

   localparam logic [6:0] F7Base = 7'h00;
   localparam logic [6:0] F7Alt  = 7'h20;

   logic [4:0] shamt;
   logic       f7_plain;

   assign shamt    = b[4:0];
   // I-type non-shift ops carry immediate bits in funct7, so it is not checked there
   assign f7_plain = itype || (funct7 == F7Base);

   // Operation decode and evaluation
   always_comb begin
      res_c   = '0;
      cond_c  = 1'b0;
      legal_c = 1'b1;
      case (aluop)
         AluAdd:   res_c = a + b;
         AluSleft: res_c = a << shamt;
         AluBranch: begin
            case (funct3)
               3'd0:    cond_c = (a == b);
               3'd1:    cond_c = (a != b);
               3'd4:    cond_c = ($signed(a) <  $signed(b));
               3'd5:    cond_c = ($signed(a) >= $signed(b));
               3'd6:    cond_c = (a <  b);
               3'd7:    cond_c = (a >= b);
               default: legal_c = 1'b0;
            endcase
         end
         default: begin
            case (funct3)
               3'd0: begin
                  if (f7_plain)               res_c = a + b;
                  else if (funct7 == F7Alt)   res_c = a - b;
                  else                        legal_c = 1'b0;
               end
               3'd1: begin
                  if (funct7 == F7Base)       res_c = a << shamt;
                  else                        legal_c = 1'b0;
               end
               3'd2: begin
                  if (f7_plain)               res_c = Xlen'($signed(a) < $signed(b));
                  else                        legal_c = 1'b0;
               end
               3'd3: begin
                  if (f7_plain)               res_c = Xlen'(a < b);
                  else                        legal_c = 1'b0;
               end
               3'd4: begin
                  if (f7_plain)               res_c = a ^ b;
                  else                        legal_c = 1'b0;
               end
               3'd5: begin
                  if (funct7 == F7Base)       res_c = a >> shamt;
                  else if (funct7 == F7Alt)   res_c = Xlen'($signed(a) >>> shamt);
                  else                        legal_c = 1'b0;
               end
               3'd6: begin
                  if (f7_plain)               res_c = a | b;
                  else                        legal_c = 1'b0;
               end
               default: begin
                  if (f7_plain)               res_c = a & b;
                  else                        legal_c = 1'b0;
               end
            endcase
         end
      endcase
   end

endmodule

// File: rtl/alu_arb.sv
// Round-robin arbiter sharing one alu32 between NumReq requesters, with a
// single registered result slot.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : request/response bus (slave side)
module alu_arb
   import alu_arb_pkg::*;
#(
   parameter int unsigned NumReq = 2
) (
   input  logic     clk_i,
   input  logic     rst_i,
   alu_arb_if.slave bus
);

   localparam int unsigned IdxW = $clog2(NumReq);

   state_e            state_q, state_d;
   logic [IdxW-1:0]   id_q, id_d;
   logic [IdxW-1:0]   ptr_q, ptr_d;
   logic [Xlen-1:0]   res_q, res_d;
   logic              zero_q, zero_d;
   logic [NumReq-1:0] valid_q, valid_d;
   logic [NumReq-1:0] ready_c;
   logic              rsp_fire_c;
   logic              issuable_c;

   logic              gnt_found_c;
   logic [IdxW-1:0]   gnt_idx_c;
   logic [IdxW-1:0]   ptr_nxt_c;
   alu_req_t          sel_c;

   logic [Xlen-1:0]   alu_res_c;
   logic              alu_cond_c;
   logic              alu_legal_c;
   logic [Xlen-1:0]   res_san_c;
   logic              zero_san_c;

   // Round-robin pick: first valid requester at or after ptr_q, wrapping
   always_comb begin
      int unsigned idx;
      int unsigned nxt;
      idx         = 0;
      nxt         = 0;
      gnt_found_c = 1'b0;
      gnt_idx_c   = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= NumReq) idx = idx - NumReq;
         if (!gnt_found_c && bus.req_valid_i[IdxW'(idx)]) begin
            gnt_found_c = 1'b1;
            gnt_idx_c   = IdxW'(idx);
         end
      end
      nxt = 32'(gnt_idx_c) + 1;
      if (nxt >= NumReq) nxt = 0;
      ptr_nxt_c = IdxW'(nxt);
   end

   assign sel_c = bus.req_i[gnt_idx_c];

   alu32 u_alu (
      .funct3  (sel_c.funct3),
      .funct7  (sel_c.funct7),
      .itype   (sel_c.itype),
      .aluop   (sel_c.aluop),
      .a       (sel_c.a),
      .b       (sel_c.b),
      .res_c   (alu_res_c),
      .cond_c  (alu_cond_c),
      .legal_c (alu_legal_c)
   );

   // Branches only produce a flag, everything else only a result; undefined encodings give 0
   assign res_san_c  = ((sel_c.aluop == AluBranch) || !alu_legal_c) ? '0 : alu_res_c;
   assign zero_san_c = (sel_c.aluop == AluBranch) && alu_legal_c && alu_cond_c;

   // Slot FSM: next state, grant and captured result
   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      ptr_d      = ptr_q;
      res_d      = res_q;
      zero_d     = zero_q;
      ready_c    = '0;
      rsp_fire_c = 1'b0;
      issuable_c = 1'b0;
      case (state_q)
         StEmpty: issuable_c = 1'b1;
         StFull: begin
            rsp_fire_c = bus.rsp_ready_i[id_q];
            issuable_c = rsp_fire_c;
            if (rsp_fire_c) state_d = StEmpty;
         end
         default: state_d = StEmpty;
      endcase
      // No grant is offered while reset is held
      if (issuable_c && gnt_found_c && !rst_i) begin
         ready_c[gnt_idx_c] = 1'b1;
         state_d            = StFull;
         id_d               = gnt_idx_c;
         ptr_d              = ptr_nxt_c;
         res_d              = res_san_c;
         zero_d             = zero_san_c;
      end
      valid_d = (state_d == StFull) ? (NumReq'(1) << id_d) : '0;
   end

   // State and result registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StEmpty;
         id_q    <= '0;
         ptr_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         valid_q <= valid_d;
      end
   end

   assign bus.req_ready_o = ready_c;
   assign bus.rsp_valid_o = valid_q;
   assign bus.rsp_res_o   = res_q;
   assign bus.rsp_zero_o  = zero_q;

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: directed requests push hand-computed responses
// into a scoreboard; a forked monitor pops and compares on every response transfer.
module tb_alu_arb;
   import alu_arb_pkg::*;

   localparam int unsigned NumReq = 2;

   logic clk = 1'b0;
   logic rst;

   alu_arb_if #(.NumReq(NumReq)) bus ();

   alu_arb #(.NumReq(NumReq)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] res;
      logic        zero;
   } exp_t;

   typedef struct {
      int          r;
      aluop_e      op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        it;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
   } vec_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_rsp(input int id, input logic [31:0] res, input logic zero);
      exp_t e;
      e.id   = id;
      e.res  = res;
      e.zero = zero;
      sb.push_back(e);
   endtask

   task automatic set_req(input int r, input aluop_e op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic it,
                          input logic [31:0] a, input logic [31:0] b);
      alu_req_t q;
      q.funct3 = f3;
      q.funct7 = f7;
      q.itype  = it;
      q.aluop  = op;
      q.a      = a;
      q.b      = b;
      bus.req_i[r]       = q;
      bus.req_valid_i[r] = 1'b1;
   endtask

   // Call at posedge+1; returns at posedge+1 after the accepting edge with valid dropped
   task automatic wait_accept(input int r);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.req_ready_o[r]) begin
            got = 1'b1;
            break;
         end
      end
      checks++;
      if (!got) begin
         fails++;
         $display("FAIL accept_r%0d: got no grant in 20 cycles, required a grant", r);
      end
      step();
      bus.req_valid_i[r] = 1'b0;
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.rsp_valid_o != '0)
            chk("rsp_valid_onehot", 32'($countones(bus.rsp_valid_o)), 32'd1);
         for (int r = 0; r < NumReq; r++) begin
            if (bus.rsp_valid_o[r] && bus.rsp_ready_i[r]) begin
               checks++;
               if (sb.size() == 0) begin
                  fails++;
                  $display("FAIL rsp_unexpected: got id=%0d res=0x%08h zero=%0b, required no response",
                           r, bus.rsp_res_o, bus.rsp_zero_o);
               end else begin
                  e = sb.pop_front();
                  if (r != e.id || bus.rsp_res_o !== e.res || bus.rsp_zero_o !== e.zero) begin
                     fails++;
                     $display("FAIL rsp: got id=%0d res=0x%08h zero=%0b, required id=%0d res=0x%08h zero=%0b",
                              r, bus.rsp_res_o, bus.rsp_zero_o, e.id, e.res, e.zero);
                  end
               end
            end
         end
      end
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{0, AluFunct,  3'd5, 7'h20, 1'b0, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0};
      vecs[1] = '{0, AluFunct,  3'd5, 7'h00, 1'b0, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0};
      vecs[2] = '{0, AluFunct,  3'd5, 7'h01, 1'b0, 32'h8000_0000, 32'd4,         32'h0,         1'b0};
      vecs[3] = '{1, AluFunct,  3'd0, 7'h20, 1'b0, 32'd10,        32'd3,         32'd7,         1'b0};
      vecs[4] = '{1, AluFunct,  3'd0, 7'h20, 1'b1, 32'd10,        32'd3,         32'd13,        1'b0};
      vecs[5] = '{0, AluBranch, 3'd2, 7'h00, 1'b0, 32'd0,         32'd0,         32'h0,         1'b0};
      vecs[6] = '{1, AluBranch, 3'd0, 7'h00, 1'b0, 32'd5,         32'd5,         32'h0,         1'b1};
      vecs[7] = '{0, AluSleft,  3'd0, 7'h00, 1'b0, 32'd1,         32'd4,         32'd16,        1'b0};
      vecs[8] = '{1, AluFunct,  3'd3, 7'h00, 1'b0, 32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0};
      vecs[9] = '{0, AluFunct,  3'd2, 7'h00, 1'b0, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0};

      rst             = 1'b1;
      bus.req_valid_i = '1;
      bus.rsp_ready_i = '0;
      for (int r = 0; r < NumReq; r++) bus.req_i[r] = '0;
      fork
         monitor();
      join_none

      // Reset state, with requests pending
      @(negedge clk);
      chk("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("reset_req_ready", 32'(bus.req_ready_o), 32'd0);
      chk("reset_res",       bus.rsp_res_o,        32'd0);
      chk("reset_zero",      32'(bus.rsp_zero_o),  32'd0);
      step();
      rst             = 1'b0;
      bus.req_valid_i = '0;
      bus.rsp_ready_i = 2'b11;

      // Single add, response visible the cycle after acceptance
      expect_rsp(0, 32'd12, 1'b0);
      set_req(0, AluAdd, 3'd0, 7'h00, 1'b0, 32'd5, 32'd7);
      wait_accept(0);
      @(negedge clk);
      chk("add_latency_valid", 32'(bus.rsp_valid_o), 32'd1);

      // Branch flag, result forced to zero
      step();
      expect_rsp(1, 32'd0, 1'b1);
      set_req(1, AluBranch, 3'd4, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1);
      wait_accept(1);
      @(negedge clk);
      chk("blt_valid", 32'(bus.rsp_valid_o), 32'd2);
      step();
      expect_rsp(1, 32'd0, 1'b0);
      set_req(1, AluBranch, 3'd6, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1);
      wait_accept(1);
      repeat (2) step();

      // Both requesters continuously valid: grants alternate, one per cycle
      expect_rsp(0, 32'd2,    1'b0);
      expect_rsp(1, 32'h0F,   1'b0);
      expect_rsp(0, 32'd2,    1'b0);
      expect_rsp(1, 32'h0F,   1'b0);
      set_req(0, AluAdd,   3'd0, 7'h00, 1'b0, 32'd1,   32'd1);
      set_req(1, AluFunct, 3'd4, 7'h00, 1'b0, 32'hF0, 32'hFF);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("alternate_grant", 32'(bus.req_ready_o), (k % 2 == 0) ? 32'd1 : 32'd2);
      end
      step();
      bus.req_valid_i = '0;
      repeat (2) step();

      // Held result: owner not ready, non-owner ready bit ignored
      bus.rsp_ready_i = 2'b00;
      expect_rsp(0, 32'd7, 1'b0);
      set_req(0, AluAdd, 3'd0, 7'h00, 1'b0, 32'd3, 32'd4);
      wait_accept(0);
      expect_rsp(1, 32'd10, 1'b0);
      set_req(1, AluAdd, 3'd0, 7'h00, 1'b0, 32'd9, 32'd1);
      bus.rsp_ready_i = 2'b10;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_req_ready", 32'(bus.req_ready_o), 32'd0);
         chk("hold_res",       bus.rsp_res_o,        32'd7);
         chk("hold_valid",     32'(bus.rsp_valid_o), 32'd1);
      end
      step();
      bus.rsp_ready_i = 2'b11;
      wait_accept(1);
      repeat (2) step();

      // Function decode table, including undefined encodings
      for (int i = 0; i < 10; i++) begin
         expect_rsp(vecs[i].r, vecs[i].res, vecs[i].zero);
         set_req(vecs[i].r, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].it, vecs[i].a, vecs[i].b);
         wait_accept(vecs[i].r);
         step();
      end
      repeat (2) step();

      // Reset while FULL discards the held result and clears the pointer
      bus.rsp_ready_i = 2'b00;
      set_req(0, AluAdd, 3'd0, 7'h00, 1'b0, 32'd1, 32'd1);
      wait_accept(0);
      @(negedge clk);
      chk("pre_reset_valid", 32'(bus.rsp_valid_o), 32'd1);
      set_req(0, AluAdd, 3'd0, 7'h00, 1'b0, 32'd2, 32'd2);
      set_req(1, AluAdd, 3'd0, 7'h00, 1'b0, 32'd5, 32'd5);
      #1;
      rst = 1'b1;
      #1;
      chk("midreset_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("midreset_ready", 32'(bus.req_ready_o), 32'd0);
      chk("midreset_res",   bus.rsp_res_o,        32'd0);
      bus.rsp_ready_i = 2'b11;
      expect_rsp(0, 32'd4,  1'b0);
      expect_rsp(1, 32'd10, 1'b0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("grant_after_reset", 32'(bus.req_ready_o), 32'd1);
      step();
      bus.req_valid_i[0] = 1'b0;
      wait_accept(1);
      repeat (3) step();

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
